// File: rtl/acc_pkg.sv
// acc_pkg: shared definitions for the conv accelerator layer scheduler.
//   - scheduler state encoding
//   - default widths shared with the weight DMA and psum writeback engine
//   - default per-layer weight stride
package acc_pkg;

    // Widths shared with the DMA / writeback command interfaces.
    localparam int LIDX_W_DEF = 4;
    localparam int WDOG_W_DEF = 24;
    localparam int CMD_ADDR_W = 32;

    // 64 output channels x 64 input channels x 3x3 kernel, one byte each.
    localparam logic [31:0] WSTRIDE_DEF = 32'd36864;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_WL_REQ  = 4'd1,
        ST_WL_WAIT = 4'd2,
        ST_CV_GO   = 4'd3,
        ST_CV_WAIT = 4'd4,
        ST_DR_REQ  = 4'd5,
        ST_DR_WAIT = 4'd6,
        ST_NEXT    = 4'd7,
        ST_FIN     = 4'd8
    } state_t;

    // States that wait on a done pulse from a downstream block.
    function automatic logic is_wait(input state_t s);
        return (s == ST_WL_WAIT) || (s == ST_CV_WAIT) || (s == ST_DR_WAIT);
    endfunction

endpackage

// File: rtl/acc_wdog.sv
// acc_wdog: loadable watchdog up-counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to zero (highest priority)
//   en         : count one cycle
//   load       : load load_val (below clr, above en)
//   load_val   : value to load
//   tc         : terminal flag, high in the enabled cycle whose increment
//                would bring the count to all-ones
module acc_wdog
    import acc_pkg::*;
#(
    parameter int WDOG_W = WDOG_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic              load,
    input  logic [WDOG_W-1:0] load_val,
    output logic              tc
);

    localparam logic [WDOG_W-1:0] LAST_BEFORE_MAX = ~WDOG_W'(1);

    logic [WDOG_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en) begin
            count_reg <= count_reg + WDOG_W'(1);
        end
    end

    // Flagging one step early makes the timeout land after exactly
    // 2^WDOG_W-1 counted cycles in a state.
    assign tc = en && (count_reg == LAST_BEFORE_MAX);

endmodule

// File: rtl/acc_layer_sched.sv
// acc_layer_sched: runs num_layers conv layers back to back. For each layer
// it issues a weight-load command, pulses conv_start and waits for conv_done,
// then issues an output-drain command. Every wait is guarded by a watchdog;
// a timeout sets the sticky err flag and returns to IDLE.
//   start/abort          : run request (IDLE only) / abort (any non-IDLE state)
//   num_layers, wbase    : run configuration, sampled on an accepted start
//   wload_*              : weight DMA command handshake and done pulse
//   conv_start/conv_done : MAC array controller strobes
//   drain_*              : psum writeback command handshake and done pulse
//   layer_idx, busy      : progress status
//   run_done, err        : completion pulse / sticky watchdog error
module acc_layer_sched
    import acc_pkg::*;
#(
    parameter int                LIDX_W  = LIDX_W_DEF,
    parameter int                WDOG_W  = WDOG_W_DEF,
    parameter int                ADDR_W  = CMD_ADDR_W,
    parameter logic [ADDR_W-1:0] WSTRIDE = ADDR_W'(WSTRIDE_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [LIDX_W-1:0] num_layers,
    input  logic [ADDR_W-1:0] wbase,
    output logic              wload_vld,
    input  logic              wload_rdy,
    output logic [ADDR_W-1:0] wload_addr,
    input  logic              wload_done,
    output logic              conv_start,
    input  logic              conv_done,
    output logic              drain_vld,
    input  logic              drain_rdy,
    input  logic              drain_done,
    output logic [LIDX_W-1:0] layer_idx,
    output logic              busy,
    output logic              run_done,
    output logic              err
);

    state_t            state_reg, state_next;
    logic [LIDX_W-1:0] layer_idx_reg;
    logic [LIDX_W-1:0] last_idx_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              err_reg;
    logic              timeout;
    logic              wdog_en;
    logic              wdog_clr;
    logic              wdog_tc;
    logic              last_layer;

    assign last_layer = (layer_idx_reg == last_idx_reg);

    // Count only while blocked on a downstream block; any state change
    // restarts the count.
    assign wdog_en  = is_wait(state_reg)
                   || ((state_reg == ST_WL_REQ) && !wload_rdy)
                   || ((state_reg == ST_DR_REQ) && !drain_rdy);
    assign wdog_clr = (state_next != state_reg);

    acc_wdog #(
        .WDOG_W (WDOG_W)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (wdog_clr),
        .en       (wdog_en),
        .load     (1'b0),
        .load_val ('0),
        .tc       (wdog_tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state. A handshake or done pulse arriving in the terminal
    // watchdog cycle still wins over the timeout. Abort overrides everything
    // outside IDLE; in IDLE a simultaneous start wins.
    always_comb begin
        state_next = state_reg;
        timeout    = 1'b0;
        case (state_reg)
            ST_IDLE:    if (start) state_next = ST_WL_REQ;
            ST_WL_REQ:  if (wload_rdy) state_next = ST_WL_WAIT;
                        else if (wdog_tc) timeout = 1'b1;
            ST_WL_WAIT: if (wload_done) state_next = ST_CV_GO;
                        else if (wdog_tc) timeout = 1'b1;
            ST_CV_GO:   state_next = ST_CV_WAIT;
            ST_CV_WAIT: if (conv_done) state_next = ST_DR_REQ;
                        else if (wdog_tc) timeout = 1'b1;
            ST_DR_REQ:  if (drain_rdy) state_next = ST_DR_WAIT;
                        else if (wdog_tc) timeout = 1'b1;
            ST_DR_WAIT: if (drain_done) state_next = ST_NEXT;
                        else if (wdog_tc) timeout = 1'b1;
            ST_NEXT:    state_next = last_layer ? ST_FIN : ST_WL_REQ;
            ST_FIN:     state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
        if (timeout) begin
            state_next = ST_IDLE;
        end
        if (abort && (state_reg != ST_IDLE)) begin
            state_next = ST_IDLE;
            timeout    = 1'b0;
        end
    end

    // Outputs decoded from the current state only.
    always_comb begin
        wload_vld  = (state_reg == ST_WL_REQ);
        conv_start = (state_reg == ST_CV_GO);
        drain_vld  = (state_reg == ST_DR_REQ);
        run_done   = (state_reg == ST_FIN);
        busy       = (state_reg != ST_IDLE);
    end

    // Run configuration, layer counter and weight address accumulator.
    // Abort and timeout leave layer_idx and the address where they were.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_idx_reg <= '0;
            last_idx_reg  <= '0;
            addr_reg      <= '0;
            err_reg       <= 1'b0;
        end else begin
            if ((state_reg == ST_IDLE) && start) begin
                last_idx_reg  <= (num_layers == '0) ? '0 : num_layers - 1'b1;
                addr_reg      <= wbase;
                layer_idx_reg <= '0;
                err_reg       <= 1'b0;
            end else if ((state_reg == ST_NEXT) && !abort && !last_layer) begin
                layer_idx_reg <= layer_idx_reg + 1'b1;
                addr_reg      <= addr_reg + WSTRIDE;
            end
            if (timeout) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign wload_addr = addr_reg;
    assign layer_idx  = layer_idx_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_acc_layer_sched.sv
// tb_acc_layer_sched: self-checking bench for acc_layer_sched. A behavioural
// responder plays the weight DMA, MAC controller and writeback engine; the
// expected command stream is computed as wbase + k*stride per layer.
module tb_acc_layer_sched;

    localparam logic [31:0] STRIDE = 32'd36864;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  num_layers = '0;
    logic [31:0] wbase = '0;
    logic        wload_vld;
    logic        wload_rdy = 1'b0;
    logic [31:0] wload_addr;
    logic        wload_done = 1'b0;
    logic        conv_start;
    logic        conv_done = 1'b0;
    logic        drain_vld;
    logic        drain_rdy = 1'b0;
    logic        drain_done = 1'b0;
    logic [3:0]  layer_idx;
    logic        busy;
    logic        run_done;
    logic        err;

    acc_layer_sched #(
        .LIDX_W (4),
        .WDOG_W (4),
        .ADDR_W (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .num_layers (num_layers),
        .wbase      (wbase),
        .wload_vld  (wload_vld),
        .wload_rdy  (wload_rdy),
        .wload_addr (wload_addr),
        .wload_done (wload_done),
        .conv_start (conv_start),
        .conv_done  (conv_done),
        .drain_vld  (drain_vld),
        .drain_rdy  (drain_rdy),
        .drain_done (drain_done),
        .layer_idx  (layer_idx),
        .busy       (busy),
        .run_done   (run_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Observations of the last job.
    logic [31:0] acc_q[$];
    int          n_conv, n_run_done, n_drain_acc;
    int          run_done_cyc, last_dd_cyc, conv_start_cyc;
    int          stall_cycles, unstable, dr_lat_bad, cyc;
    bit          first_vld, first_err, job_timeout;
    logic [3:0]  first_lidx;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rnd(input int lo, input int hi);
        return int'($urandom_range(hi, lo));
    endfunction

    // Launch one run and play the downstream blocks until the scheduler
    // returns to IDLE or max_cyc cycles pass.
    task automatic run_job(input logic [3:0] nl, input logic [31:0] base,
                           input int dmin, input int dmax,
                           input int stall_wl, input int stall_dr,
                           input bit conv_resp, input int abort_layer,
                           input bit stray, input int max_cyc);
        int          wl_t, cv_t, dr_t, wl_left, dr_left, cd_cyc;
        logic [31:0] held_addr;
        bit          wl_prev, dv_prev;
        acc_q.delete();
        n_conv = 0; n_run_done = 0; n_drain_acc = 0;
        run_done_cyc = -1; last_dd_cyc = -100; conv_start_cyc = -1;
        stall_cycles = 0; unstable = 0; dr_lat_bad = 0;
        wl_t = 0; cv_t = 0; dr_t = 0; cd_cyc = -100;
        wl_left = stall_wl; dr_left = stall_dr;
        held_addr = '0; wl_prev = 0; dv_prev = 0;
        num_layers = nl; wbase = base; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        first_vld = wload_vld; first_err = err; first_lidx = layer_idx;
        job_timeout = 1;
        while (cyc < max_cyc) begin
            wload_done = 0; conv_done = 0; drain_done = 0; abort = 0; start = 0;
            if (run_done) begin
                n_run_done++;
                run_done_cyc = cyc;
            end
            if (!busy) begin
                job_timeout = 0;
                break;
            end
            if (wl_t > 0) begin
                wl_t--;
                if (wl_t == 0) wload_done = 1;
            end
            if (cv_t > 0) begin
                cv_t--;
                if (cv_t == 0) begin
                    conv_done = 1;
                    cd_cyc = cyc;
                    if (abort_layer == int'(layer_idx)) abort = 1;
                end
            end
            if (dr_t > 0) begin
                dr_t--;
                if (dr_t == 0) begin
                    drain_done = 1;
                    last_dd_cyc = cyc;
                end
            end
            if (wload_vld) begin
                if (!wl_prev) held_addr = wload_addr;
                else if (wload_addr !== held_addr) unstable++;
                if (wl_left > 0) begin
                    wload_rdy = 0;
                    wl_left--;
                    stall_cycles++;
                end else begin
                    wload_rdy = 1;
                    acc_q.push_back(wload_addr);
                    wl_t = rnd(dmin, dmax);
                end
            end else begin
                wload_rdy = 0;
                wl_left = stall_wl;
            end
            wl_prev = wload_vld;
            if (conv_start) begin
                n_conv++;
                conv_start_cyc = cyc;
                if (conv_resp) cv_t = rnd(dmin, dmax);
            end
            if (drain_vld) begin
                if (!dv_prev && (cyc - cd_cyc != 1)) dr_lat_bad++;
                if (dr_left > 0) begin
                    drain_rdy = 0;
                    dr_left--;
                end else begin
                    drain_rdy = 1;
                    n_drain_acc++;
                    dr_t = rnd(dmin, dmax);
                end
            end else begin
                drain_rdy = 0;
                dr_left = stall_dr;
            end
            dv_prev = drain_vld;
            // Stray conv_done while waiting for weights; start while busy.
            if (stray && wl_t > 0 && !wload_vld) conv_done = 1;
            if (stray && dr_t > 0) begin
                start = 1;
                num_layers = nl + 4'd3;
                wbase = ~base;
            end
            tick();
            cyc++;
        end
        wload_rdy = 0; drain_rdy = 0; wload_done = 0; conv_done = 0;
        drain_done = 0; abort = 0; start = 0;
        $display("job: layers=%0d base=%08h cmds=%0d convs=%0d drains=%0d run_done=%0d err=%0b cycles=%0d",
                 nl, base, acc_q.size(), n_conv, n_drain_acc, n_run_done, err, cyc);
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) tick();
        n_checks++;
        if ({wload_vld, conv_start, drain_vld, busy, run_done, err} !== 6'b0)
            $display("FAIL reset_flags: got %b expected 000000",
                     {wload_vld, conv_start, drain_vld, busy, run_done, err});
        else n_pass++;
        n_checks++;
        if (layer_idx !== 4'd0) $display("FAIL reset_layer_idx: got %0d expected 0", layer_idx);
        else n_pass++;
        n_checks++;
        if (wload_addr !== 32'd0) $display("FAIL reset_wload_addr: got %08h expected 0", wload_addr);
        else n_pass++;
        rst_n = 1;
        tick();
    endtask

    task automatic test_three_layers();
        logic [31:0] exp_addr[3];
        exp_addr[0] = 32'h1000; exp_addr[1] = 32'hA000; exp_addr[2] = 32'h13000;
        run_job(4'd3, 32'h1000, 5, 5, 0, 0, 1, -1, 0, 400);
        n_checks++;
        if (job_timeout) $display("FAIL three_timeout: run did not end within bound");
        else n_pass++;
        n_checks++;
        if (first_vld !== 1'b1) $display("FAIL three_start_latency: wload_vld=%b expected 1", first_vld);
        else n_pass++;
        n_checks++;
        if (acc_q.size() != 3) $display("FAIL three_cmd_count: got %0d expected 3", acc_q.size());
        else n_pass++;
        for (int k = 0; k < 3 && k < acc_q.size(); k++) begin
            n_checks++;
            if (acc_q[k] !== exp_addr[k])
                $display("FAIL three_addr%0d: got %08h expected %08h", k, acc_q[k], exp_addr[k]);
            else n_pass++;
        end
        n_checks++;
        if (n_conv != 3) $display("FAIL three_conv_count: got %0d expected 3", n_conv);
        else n_pass++;
        n_checks++;
        if (n_run_done != 1) $display("FAIL three_run_done_count: got %0d expected 1", n_run_done);
        else n_pass++;
        n_checks++;
        if (run_done_cyc - last_dd_cyc != 2)
            $display("FAIL three_run_done_latency: got %0d expected 2", run_done_cyc - last_dd_cyc);
        else n_pass++;
        n_checks++;
        if (layer_idx !== 4'd2) $display("FAIL three_final_layer_idx: got %0d expected 2", layer_idx);
        else n_pass++;
        n_checks++;
        if (dr_lat_bad != 0) $display("FAIL three_drain_latency: %0d late drain_vld expected 0", dr_lat_bad);
        else n_pass++;
    endtask

    task automatic test_zero_layers();
        run_job(4'd0, 32'h2000, 1, 4, 0, 0, 1, -1, 0, 200);
        n_checks++;
        if (acc_q.size() != 1 || acc_q[0] !== 32'h2000)
            $display("FAIL zero_cmds: got %0d cmds expected 1 at 00002000", acc_q.size());
        else n_pass++;
        n_checks++;
        if (n_conv != 1 || n_run_done != 1)
            $display("FAIL zero_run: got conv=%0d run_done=%0d expected 1/1", n_conv, n_run_done);
        else n_pass++;
        n_checks++;
        if (layer_idx !== 4'd0) $display("FAIL zero_layer_idx: got %0d expected 0", layer_idx);
        else n_pass++;
    endtask

    task automatic test_rdy_stall();
        run_job(4'd2, 32'h4000, 3, 3, 10, 0, 1, -1, 0, 300);
        n_checks++;
        if (stall_cycles != 20) $display("FAIL stall_cycles: got %0d expected 20", stall_cycles);
        else n_pass++;
        n_checks++;
        if (unstable != 0) $display("FAIL stall_addr_stable: got %0d changes expected 0", unstable);
        else n_pass++;
        n_checks++;
        if (acc_q.size() != 2) $display("FAIL stall_cmd_count: got %0d expected 2", acc_q.size());
        else n_pass++;
        n_checks++;
        if (acc_q.size() == 2 && acc_q[1] !== 32'h4000 + STRIDE)
            $display("FAIL stall_addr1: got %08h expected %08h", acc_q[1], 32'h4000 + STRIDE);
        else n_pass++;
        n_checks++;
        if (n_run_done != 1) $display("FAIL stall_run_done: got %0d expected 1", n_run_done);
        else n_pass++;
    endtask

    task automatic test_watchdog();
        run_job(4'd2, 32'h8000, 3, 3, 0, 0, 0, -1, 0, 200);
        n_checks++;
        if (job_timeout) $display("FAIL wdog_no_return: scheduler never left CV_WAIT");
        else n_pass++;
        n_checks++;
        if (cyc - conv_start_cyc != 16)
            $display("FAIL wdog_cv_wait_cycles: got %0d expected 15", cyc - conv_start_cyc - 1);
        else n_pass++;
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0)
            $display("FAIL wdog_err_busy: got err=%b busy=%b expected 1/0", err, busy);
        else n_pass++;
        n_checks++;
        if (n_run_done != 0) $display("FAIL wdog_run_done: got %0d expected 0", n_run_done);
        else n_pass++;
        run_job(4'd1, 32'h100, 2, 2, 0, 0, 1, -1, 0, 200);
        n_checks++;
        if (first_err !== 1'b0 || err !== 1'b0)
            $display("FAIL wdog_err_clear: got %b/%b expected 0/0", first_err, err);
        else n_pass++;
        n_checks++;
        if (n_run_done != 1) $display("FAIL wdog_rerun_done: got %0d expected 1", n_run_done);
        else n_pass++;
    endtask

    task automatic test_abort();
        int bad;
        run_job(4'd3, 32'h3000, 2, 4, 0, 0, 1, 1, 0, 400);
        n_checks++;
        if (job_timeout || busy !== 1'b0) $display("FAIL abort_idle: busy=%b expected 0", busy);
        else n_pass++;
        n_checks++;
        if (layer_idx !== 4'd1) $display("FAIL abort_layer_idx: got %0d expected 1", layer_idx);
        else n_pass++;
        n_checks++;
        if (n_conv != 2 || n_drain_acc != 1 || n_run_done != 0)
            $display("FAIL abort_counts: got conv=%0d drain=%0d run_done=%0d expected 2/1/0",
                     n_conv, n_drain_acc, n_run_done);
        else n_pass++;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (drain_vld || wload_vld || busy || err) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) $display("FAIL abort_quiet: got %0d active cycles expected 0", bad);
        else n_pass++;
        run_job(4'd2, 32'h5000, 2, 3, 0, 0, 1, -1, 0, 300);
        n_checks++;
        if (first_lidx !== 4'd0 || acc_q.size() < 1 || acc_q[0] !== 32'h5000)
            $display("FAIL abort_restart: got layer_idx=%0d cmds=%0d expected 0 at 00005000",
                     first_lidx, acc_q.size());
        else n_pass++;
        n_checks++;
        if (n_run_done != 1) $display("FAIL abort_restart_done: got %0d expected 1", n_run_done);
        else n_pass++;
    endtask

    task automatic test_stray();
        int moved;
        moved = 0;
        conv_done = 1; tick(); conv_done = 0;
        if (busy || conv_start) moved++;
        wload_done = 1; tick(); wload_done = 0;
        if (busy || conv_start) moved++;
        drain_done = 1; abort = 1; tick(); drain_done = 0; abort = 0;
        if (busy || conv_start) moved++;
        tick();
        n_checks++;
        if (moved != 0) $display("FAIL stray_idle: got %0d reactions expected 0", moved);
        else n_pass++;
        run_job(4'd2, 32'h6000, 3, 5, 0, 0, 1, -1, 1, 400);
        n_checks++;
        if (n_conv != 2 || n_run_done != 1)
            $display("FAIL stray_run: got conv=%0d run_done=%0d expected 2/1", n_conv, n_run_done);
        else n_pass++;
        n_checks++;
        if (acc_q.size() != 2 || acc_q[1] !== 32'h6000 + STRIDE)
            $display("FAIL stray_cmds: got %0d cmds expected 2 ending %08h", acc_q.size(), 32'h6000 + STRIDE);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0]  nl;
        logic [31:0] base;
        logic [31:0] exp_a;
        int          exp_n;
        for (int r = 0; r < 6; r++) begin
            nl   = 4'($urandom_range(5, 0));
            base = (r == 0) ? 32'hFFFF_8000 : $urandom;
            exp_n = (nl == 0) ? 1 : int'(nl);
            run_job(nl, base, 1, 8, rnd(0, 5), rnd(0, 5), 1, -1, 0, 600);
            n_checks++;
            if (job_timeout || acc_q.size() != exp_n)
                $display("FAIL rand%0d_cmd_count: got %0d expected %0d", r, acc_q.size(), exp_n);
            else n_pass++;
            for (int k = 0; k < exp_n && k < acc_q.size(); k++) begin
                exp_a = base + STRIDE * 32'(k);
                n_checks++;
                if (acc_q[k] !== exp_a)
                    $display("FAIL rand%0d_addr%0d: got %08h expected %08h", r, k, acc_q[k], exp_a);
                else n_pass++;
            end
            n_checks++;
            if (n_conv != exp_n || n_run_done != 1 || err !== 1'b0)
                $display("FAIL rand%0d_run: got conv=%0d run_done=%0d err=%b expected %0d/1/0",
                         r, n_conv, n_run_done, err, exp_n);
            else n_pass++;
            n_checks++;
            if (int'(layer_idx) != exp_n - 1 || run_done_cyc - last_dd_cyc != 2)
                $display("FAIL rand%0d_end: got layer_idx=%0d gap=%0d expected %0d/2",
                         r, layer_idx, run_done_cyc - last_dd_cyc, exp_n - 1);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        num_layers = 4'd2; wbase = 32'hABC0; start = 1;
        tick();
        start = 0; wload_rdy = 0;
        repeat (3) tick();
        n_checks++;
        if (wload_vld !== 1'b1 || wload_addr !== 32'hABC0)
            $display("FAIL areset_pre: got vld=%b addr=%08h expected 1/0000abc0", wload_vld, wload_addr);
        else n_pass++;
        #2 rst_n = 0;
        #1;
        n_checks++;
        if ({busy, wload_vld} !== 2'b00 || wload_addr !== 32'd0 || layer_idx !== 4'd0)
            $display("FAIL areset_immediate: got busy=%b vld=%b addr=%08h expected 0/0/0",
                     busy, wload_vld, wload_addr);
        else n_pass++;
        tick();
        rst_n = 1;
        tick();
    endtask

    initial begin
        test_reset();
        test_three_layers();
        test_zero_layers();
        test_rdy_stall();
        test_watchdog();
        test_abort();
        test_stray();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
